// File: rtl/hazard_fwd_unit_pkg.sv
// rtl/hazard_fwd_unit_pkg.sv - shared types and helpers for the hazard/forwarding unit
package hazard_pkg;

  localparam int DEF_REG_AW  = 5;
  localparam int SEL_REGFILE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // Forward select encoding: stage k is reported as k+1 so 0 can mean "regfile".
  function automatic int fwd_stage_sel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - pipeline-side bundle for the hazard/forwarding unit
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int SEL_W  = $clog2(NFWD + 1)
);

  logic [NSRC*REG_AW-1:0]  id_src;
  logic [NSRC-1:0]         id_src_vld;
  logic                    id_mdu_op;
  logic [NSRC*REG_AW-1:0]  ex_src;
  logic [REG_AW-1:0]       ex_rd;
  logic                    ex_memread;
  logic                    ex_mdu_start;
  logic [NFWD*REG_AW-1:0]  fwd_wesel;
  logic [NFWD-1:0]         fwd_regwrite;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic                    stall_id;
  logic                    bubble_ex;
  logic                    mdu_busy;
  logic                    mdu_done;
  logic [REG_AW-1:0]       mdu_wesel;
  logic [31:0]             stall_cnt;

  modport master (
    output id_src, id_src_vld, id_mdu_op, ex_src, ex_rd, ex_memread,
           ex_mdu_start, fwd_wesel, fwd_regwrite,
    input  fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wesel, stall_cnt
  );

  modport slave (
    input  id_src, id_src_vld, id_mdu_op, ex_src, ex_rd, ex_memread,
           ex_mdu_start, fwd_wesel, fwd_regwrite,
    output fwd_sel, stall_id, bubble_ex, mdu_busy, mdu_done, mdu_wesel, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_match.sv
// rtl/hazard_fwd_unit_fwd_match.sv - one EX source against all forwarding stages
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int NFWD   = 2,
  parameter int SEL_W  = $clog2(NFWD + 1)
) (
  input  logic [REG_AW-1:0]      src,
  input  logic [NFWD*REG_AW-1:0] wesel,
  input  logic [NFWD-1:0]        regwrite,
  output logic [SEL_W-1:0]       sel
);

  // Walk from farthest to nearest so the nearest matching stage is applied last.
  always_comb begin
    sel = SEL_W'(SEL_REGFILE);
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (regwrite[k] && (wesel[k*REG_AW +: REG_AW] != '0) &&
          (wesel[k*REG_AW +: REG_AW] == src)) begin
        sel = SEL_W'(fwd_stage_sel(k));
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX bypass selects, load-use/MDU stalls, MDU busy tracking
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NSRC    = 2,
  parameter int NFWD    = 2,
  parameter int MDU_LAT = 4,
  parameter int SEL_W   = $clog2(NFWD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  hazard_fwd_unit_if.slave hif
);

  localparam int CNT_W = $clog2(MDU_LAT);

  mdu_state_t        state_q;
  logic [CNT_W-1:0]  countdown_q;
  logic [REG_AW-1:0] wesel_q;
  logic [31:0]       stall_cnt_q;

  logic mdu_busy;
  logic mdu_done;
  logic load_use;
  logic mdu_raw;
  logic mdu_struct;
  logic stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .NFWD   (NFWD),
      .SEL_W  (SEL_W)
    ) u_match (
      .src      (hif.ex_src[i*REG_AW +: REG_AW]),
      .wesel    (hif.fwd_wesel),
      .regwrite (hif.fwd_regwrite),
      .sel      (hif.fwd_sel[i*SEL_W +: SEL_W])
    );
  end

  assign mdu_busy = (state_q == BUSY);
  assign mdu_done = mdu_busy && (countdown_q == '0);

  always_comb begin
    load_use = 1'b0;
    mdu_raw  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hif.id_src_vld[i] && (hif.id_src[i*REG_AW +: REG_AW] == hif.ex_rd))
        load_use = 1'b1;
      if (hif.id_src_vld[i] && (hif.id_src[i*REG_AW +: REG_AW] == wesel_q))
        mdu_raw = 1'b1;
    end
    load_use   = load_use && hif.ex_memread && (hif.ex_rd != '0);
    // Held through the done cycle: the result only lands in the regfile at its end.
    mdu_raw    = mdu_raw && mdu_busy && (wesel_q != '0);
    mdu_struct = mdu_busy && !mdu_done && hif.id_mdu_op;
    stall      = load_use || mdu_raw || mdu_struct;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      countdown_q <= '0;
      wesel_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hif.ex_mdu_start) begin
            state_q     <= BUSY;
            wesel_q     <= hif.ex_rd;
            countdown_q <= CNT_W'(MDU_LAT - 1);
          end
        end
        BUSY: begin
          if (countdown_q != '0) begin
            countdown_q <= countdown_q - 1'b1;
          end else if (hif.ex_mdu_start) begin
            wesel_q     <= hif.ex_rd;
            countdown_q <= CNT_W'(MDU_LAT - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assert property (@(posedge clk) disable iff (rst)
                   !(mdu_busy && (countdown_q != '0) && hif.ex_mdu_start));

  assign hif.stall_id  = stall;
  assign hif.bubble_ex = stall;
  assign hif.mdu_busy  = mdu_busy;
  assign hif.mdu_done  = mdu_done;
  assign hif.mdu_wesel = wesel_q;
  assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vectors for hazard_fwd_unit
module tb_hazard_fwd_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  hazard_fwd_unit_if #(.REG_AW(5), .NSRC(2), .NFWD(2), .SEL_W(2)) hif ();

  hazard_fwd_unit #(
    .REG_AW  (5),
    .NSRC    (2),
    .NFWD    (2),
    .MDU_LAT (4),
    .SEL_W   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    hif.id_src       = '0;
    hif.id_src_vld   = '0;
    hif.id_mdu_op    = 1'b0;
    hif.ex_src       = '0;
    hif.ex_rd        = '0;
    hif.ex_memread   = 1'b0;
    hif.ex_mdu_start = 1'b0;
    hif.fwd_wesel    = '0;
    hif.fwd_regwrite = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_busy",  32'(hif.mdu_busy),  32'd0);
    check("rst_done",  32'(hif.mdu_done),  32'd0);
    check("rst_cnt",   hif.stall_cnt,      32'd0);
    check("rst_stall", 32'(hif.stall_id),  32'd0);
    check("rst_wesel", 32'(hif.mdu_wesel), 32'd0);
    check("rst_fwd",   32'(hif.fwd_sel),   32'd0);

    // forwarding priority
    hif.ex_src       = {5'd0, 5'd5};
    hif.fwd_wesel    = {5'd5, 5'd5};
    hif.fwd_regwrite = 2'b11;
    #1;
    check("fwd_mem_wins", 32'(hif.fwd_sel[1:0]), 32'd1);
    check("fwd_src1_rf",  32'(hif.fwd_sel[3:2]), 32'd0);
    hif.fwd_regwrite = 2'b10;
    #1;
    check("fwd_wb_only", 32'(hif.fwd_sel[1:0]), 32'd2);
    hif.ex_src = {5'd0, 5'd0};
    #1;
    check("fwd_src_r0", 32'(hif.fwd_sel[1:0]), 32'd0);
    hif.fwd_wesel    = {5'd0, 5'd0};
    hif.fwd_regwrite = 2'b11;
    #1;
    check("fwd_r0_never", 32'(hif.fwd_sel), 32'd0);
    hif.ex_src       = {5'd7, 5'd3};
    hif.fwd_wesel    = {5'd7, 5'd3};
    hif.fwd_regwrite = 2'b11;
    #1;
    check("fwd_both_srcs", 32'(hif.fwd_sel), 32'b10_01);

    // load-use
    clr_inputs();
    next_cycle();
    hif.ex_memread = 1'b1;
    hif.ex_rd      = 5'd8;
    hif.id_src     = {5'd8, 5'd0};
    hif.id_src_vld = 2'b10;
    #1;
    check("lu_stall",  32'(hif.stall_id),  32'd1);
    check("lu_bubble", 32'(hif.bubble_ex), 32'd1);
    next_cycle();
    check("lu_cnt", hif.stall_cnt, 32'd1);
    hif.id_src_vld = 2'b01;
    #1;
    check("lu_invalid_src", 32'(hif.stall_id), 32'd0);
    hif.id_src_vld = 2'b11;
    hif.ex_rd      = 5'd0;
    hif.id_src     = {5'd0, 5'd0};
    #1;
    check("lu_r0", 32'(hif.stall_id), 32'd0);
    next_cycle();
    check("lu_cnt_hold", hif.stall_cnt, 32'd1);

    // MDU data hazard, issue at t0
    do_reset();
    hif.ex_mdu_start = 1'b1;
    hif.ex_rd        = 5'd9;
    hif.id_src       = {5'd0, 5'd9};
    hif.id_src_vld   = 2'b01;
    #1;
    check("mdu_t0_stall", 32'(hif.stall_id), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      hif.ex_mdu_start = 1'b0;
      hif.ex_rd        = 5'd0;
      #1;
      check($sformatf("mdu_busy_t%0d", t),  32'(hif.mdu_busy),  32'd1);
      check($sformatf("mdu_done_t%0d", t),  32'(hif.mdu_done),  (t == 4) ? 32'd1 : 32'd0);
      check($sformatf("mdu_stall_t%0d", t), 32'(hif.stall_id),  32'd1);
    end
    check("mdu_wesel", 32'(hif.mdu_wesel), 32'd9);
    next_cycle();
    check("mdu_t5_busy",  32'(hif.mdu_busy),  32'd0);
    check("mdu_t5_stall", 32'(hif.stall_id),  32'd0);
    check("mdu_t5_cnt",   hif.stall_cnt,      32'd4);
    check("mdu_wesel_hold", 32'(hif.mdu_wesel), 32'd9);

    // structural hazard and back-to-back issue
    clr_inputs();
    hif.ex_mdu_start = 1'b1;
    hif.ex_rd        = 5'd3;
    next_cycle();
    hif.ex_mdu_start = 1'b0;
    hif.ex_rd        = 5'd0;
    hif.id_mdu_op    = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      #1;
      check($sformatf("st_stall_t%0d", t), 32'(hif.stall_id), 32'd1);
      next_cycle();
    end
    #1;
    check("st_done_t4",  32'(hif.mdu_done), 32'd1);
    check("st_stall_t4", 32'(hif.stall_id), 32'd0);
    hif.ex_mdu_start = 1'b1;
    hif.ex_rd        = 5'd12;
    next_cycle();
    hif.ex_mdu_start = 1'b0;
    hif.ex_rd        = 5'd0;
    hif.id_mdu_op    = 1'b0;
    #1;
    check("b2b_busy",  32'(hif.mdu_busy),  32'd1);
    check("b2b_done",  32'(hif.mdu_done),  32'd0);
    check("b2b_wesel", 32'(hif.mdu_wesel), 32'd12);
    repeat (3) next_cycle();
    check("b2b_done_t8", 32'(hif.mdu_done), 32'd1);
    next_cycle();
    check("b2b_idle", 32'(hif.mdu_busy), 32'd0);

    // reset mid-op
    do_reset();
    hif.ex_mdu_start = 1'b1;
    hif.ex_rd        = 5'd9;
    hif.id_src       = {5'd0, 5'd9};
    hif.id_src_vld   = 2'b01;
    next_cycle();
    hif.ex_mdu_start = 1'b0;
    hif.ex_rd        = 5'd0;
    next_cycle();
    check("rm_t2_busy", 32'(hif.mdu_busy), 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("rm_busy",  32'(hif.mdu_busy),  32'd0);
    check("rm_done",  32'(hif.mdu_done),  32'd0);
    check("rm_cnt",   hif.stall_cnt,      32'd0);
    check("rm_stall", 32'(hif.stall_id),  32'd0);
    next_cycle();
    check("rm_no_done", 32'(hif.mdu_done), 32'd0);

    // stall counter saturation
    clr_inputs();
    hif.ex_memread = 1'b1;
    hif.ex_rd      = 5'd4;
    hif.id_src     = {5'd0, 5'd4};
    hif.id_src_vld = 2'b01;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preset", hif.stall_cnt, 32'hFFFF_FFFE);
    for (int t = 1; t <= 3; t++) begin
      next_cycle();
      check($sformatf("sat_c%0d", t), hif.stall_cnt, 32'hFFFF_FFFF);
    end

    clr_inputs();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
